// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (request-to-send, 11-bit frame, ACK check)
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   tx_data, tx_valid        command byte and send request
//   tx_ready                 high only in IDLE; byte accepted on tx_valid & tx_ready
//   ps2c_in, ps2d_in         sampled PS2C / PS2D lines
//   ps2c_oe, ps2d_oe         1 = pull line low, 0 = release
//   busy                     high in every state except IDLE
//   done, err                one-cycle result pulses
//   err_code                 01 timeout, 10 no ACK; held until next accept
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic [1:0] c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] c_hist_q, d_hist_q;
  logic c_filt_q, c_filt_d, d_filt_q, d_filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] idx_q, idx_d;
  logic ps2c_oe_q, ps2c_oe_d, ps2d_oe_q, ps2d_oe_d;
  logic done_q, done_d, err_q, err_d;
  logic [1:0] code_q, code_d;
  logic fall_c, timeout;
  // A filtered level only moves once the whole history window agrees on the new value.
  always_comb c_filt_d = &c_hist_q ? 1'b1 : ~|c_hist_q ? 1'b0 : c_filt_q;
  always_comb d_filt_d = &d_hist_q ? 1'b1 : ~|d_hist_q ? 1'b0 : d_filt_q;
  assign fall_c = c_filt_q & ~c_filt_d;
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    idx_d = idx_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    done_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        frame_d = {1'b1, ~^tx_data, tx_data};
        code_d = 2'b00;
        cnt_d = '0;
        ps2c_oe_d = 1'b1;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          ps2d_oe_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        ps2c_oe_d = 1'b0;
        cnt_d = '0;
        idx_d = 4'd0;
        state_d = BITS;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b0;
          err_d = 1'b1;
          code_d = 2'b01;
          state_d = IDLE;
        end else begin
          if (fall_c) cnt_d = '0;
          if (state_q == WAIT_IDLE && c_filt_q && d_filt_q) begin
            done_d = 1'b1;
            state_d = IDLE;
          end else if (fall_c && state_q == ACK) begin
            err_d = d_filt_q;
            code_d = d_filt_q ? 2'b10 : code_q;
            state_d = d_filt_q ? IDLE : WAIT_IDLE;
          end else if (fall_c && state_q == BITS) begin
            ps2d_oe_d = ~frame_q[0];
            frame_d = frame_q >> 1;
            idx_d = idx_q + 4'd1;
            state_d = (idx_q == 4'd9) ? ACK : BITS;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_hist_q <= '1;
      d_hist_q <= '1;
      c_filt_q <= 1'b1;
      d_filt_q <= 1'b1;
      cnt_q <= '0;
      frame_q <= '0;
      idx_q <= 4'd0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= 2'b00;
    end else begin
      state_q <= state_d;
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      c_hist_q <= FILTER_LEN'({c_hist_q, c_sync_q[1]});
      d_hist_q <= FILTER_LEN'({d_hist_q, d_sync_q[1]});
      c_filt_q <= c_filt_d;
      d_filt_q <= d_filt_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
  assign tx_ready = state_q == IDLE;
  assign busy = ~tx_ready;
  assign ps2c_oe = ps2c_oe_q;
  assign ps2d_oe = ps2d_oe_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with open-drain device model and frame scoreboard for ps2_host_tx
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2c_oe, ps2d_oe, busy, done, err;
  logic [1:0] err_code;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  logic ps2c_line, ps2d_line;
  int compared = 0;
  int mismatched = 0;
  int done_n = 0;
  int err_n = 0;
  int cyc = 0;
  int tog_cyc = 0;
  int err_cyc = 0;
  int inh_run = 0;
  int inh_last = 0;
  int d0, e0;
  logic [1:0] last_code = 2'b00;
  logic prev_d = 1'b0;
  logic exp_q[$];
  assign ps2c_line = ~(ps2c_oe | dev_c_low);
  assign ps2d_line = ~(ps2d_oe | dev_d_low);
  ps2_host_tx #(.INHIBIT_CYCLES(20), .FILTER_LEN(2), .TIMEOUT_CYCLES(500)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2c_in(ps2c_line), .ps2d_in(ps2d_line), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (done) done_n++;
    if (err) begin
      err_n++;
      last_code = err_code;
      err_cyc = cyc;
    end
    if (done | err) chk("done_err_exclusive", int'(done & err), 0);
    if (ps2d_oe !== prev_d && !err) tog_cyc = cyc;
    prev_d = ps2d_oe;
    if (ps2c_oe & ~ps2d_oe) inh_run++;
    else begin
      if (inh_run != 0) inh_last = inh_run;
      inh_run = 0;
    end
  end
  task automatic send(input logic [7:0] b);
    chk("ready_before_send", int'(tx_ready), 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
  endtask
  task automatic dev_frame(input int nclk, input logic ack, input logic glitch);
    int n = 0;
    while (!(ps2c_line === 1'b1 && ps2d_line === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rts_seen", int'(n < 300), 1);
    chk("inhibit_len", inh_last, 20);
    chk("busy_in_frame", int'(busy), 1);
    chk("not_ready_in_frame", int'(tx_ready), 0);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11) begin
        dev_d_low = ack;
        repeat (10) @(negedge clk);
      end
      dev_c_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_c_low = 1'b0;
      @(negedge clk);
      if (k <= 10) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
        else chk($sformatf("frame_bit%0d", k - 1), int'(ps2d_line), int'(exp_q.pop_front()));
      end
      if (glitch && k == 3) begin
        repeat (8) @(negedge clk);
        dev_c_low = 1'b1;
        @(negedge clk);
        dev_c_low = 1'b0;
        repeat (10) @(negedge clk);
      end else repeat (19) @(negedge clk);
    end
    dev_d_low = 1'b0;
  endtask
  task automatic wait_end(input int dn, input int en);
    int n = 0;
    while (done_n == dn && err_n == en && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("result_seen", int'(n < 1000), 1);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ps2c_oe", int'(ps2c_oe), 0);
    chk("rst_ps2d_oe", int'(ps2d_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_tx_ready", int'(tx_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    foreach (exp_q[i]) exp_q.delete();
    d0 = done_n; e0 = err_n;
    send(8'hED);
    dev_frame(11, 1'b1, 1'b0);
    wait_end(d0, e0);
    chk("ed_done", done_n - d0, 1);
    chk("ed_no_err", err_n - e0, 0);
    chk("ed_sb_empty", exp_q.size(), 0);
    chk("ed_ready_back", int'(tx_ready), 1);
    d0 = done_n; e0 = err_n;
    send(8'h07);
    dev_frame(11, 1'b1, 1'b0);
    wait_end(d0, e0);
    chk("x07_done", done_n - d0, 1);
    d0 = done_n; e0 = err_n;
    send(8'h00);
    dev_frame(11, 1'b1, 1'b0);
    wait_end(d0, e0);
    chk("x00_done", done_n - d0, 1);
    chk("x00_no_err", err_n - e0, 0);
    d0 = done_n; e0 = err_n;
    send(8'h3C);
    dev_frame(11, 1'b0, 1'b0);
    wait_end(d0, e0);
    chk("noack_err", err_n - e0, 1);
    chk("noack_no_done", done_n - d0, 0);
    chk("noack_code", int'(last_code), 2);
    chk("noack_code_held", int'(err_code), 2);
    chk("noack_c_rel", int'(ps2c_oe), 0);
    chk("noack_d_rel", int'(ps2d_oe), 0);
    d0 = done_n; e0 = err_n;
    send(8'h05);
    dev_frame(4, 1'b1, 1'b0);
    exp_q.delete();
    wait_end(d0, e0);
    chk("to_err", err_n - e0, 1);
    chk("to_code", int'(last_code), 1);
    chk("to_latency", err_cyc - tog_cyc, 500);
    chk("to_c_rel", int'(ps2c_oe), 0);
    chk("to_d_rel", int'(ps2d_oe), 0);
    d0 = done_n; e0 = err_n;
    send(8'hF4);
    chk("accept_clears_code", int'(err_code), 0);
    dev_frame(11, 1'b1, 1'b0);
    wait_end(d0, e0);
    chk("f4_done", done_n - d0, 1);
    chk("f4_no_err", err_n - e0, 0);
    d0 = done_n; e0 = err_n;
    send(8'hA5);
    dev_frame(5, 1'b1, 1'b0);
    exp_q.delete();
    chk("bit4_driven", int'(ps2d_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_c", int'(ps2c_oe), 0);
    chk("mid_rst_d", int'(ps2d_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    send(8'h55);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("inh_c_driven", int'(ps2c_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("inh_rst_c", int'(ps2c_oe), 0);
    chk("inh_rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_no_done", done_n - d0, 0);
    chk("rst_no_err", err_n - e0, 0);
    d0 = done_n; e0 = err_n;
    send(8'h12);
    repeat (3) @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, 1'b1);
    wait_end(d0, e0);
    chk("busy_send_done", done_n - d0, 1);
    chk("busy_send_no_err", err_n - e0, 0);
    chk("busy_send_sb_empty", exp_q.size(), 0);
    repeat (60) @(negedge clk);
    chk("no_queued_frame", int'(busy), 0);
    chk("no_queued_c", int'(ps2c_oe), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
